// File: rtl/team_turn_ctrl_pkg.sv
// Shared codes for the two-team turn scheduler: display status, team and winner
// encodings, plus the controller state enum.
package turn_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_TURN = 2'b10;
    localparam logic [1:0] ST_END  = 2'b11;

    localparam logic [1:0] TEAM_NONE = 2'b00;
    localparam logic [1:0] TEAM1     = 2'b01;
    localparam logic [1:0] TEAM2     = 2'b10;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_TEAM1 = 2'b01;
    localparam logic [1:0] WIN_TEAM2 = 2'b10;
    localparam logic [1:0] WIN_TIE   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_COMMIT,
        S_HOLD,
        S_DONE
    } fsm_state_t;

    // COMMIT still shows PLAY so the VGA path only switches once the total is final.
    function automatic logic [1:0] status_of(input fsm_state_t s);
        case (s)
            S_PLAY, S_COMMIT: status_of = ST_PLAY;
            S_HOLD:           status_of = ST_TURN;
            S_DONE:           status_of = ST_END;
            default:          status_of = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/team_turn_ctrl_hold_timer.sv
// Loadable down-counter; stops at zero and flags done while it sits there.
// Sized by the caller so it can be reused for apple/mine respawn delays.
module hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == '0);

endmodule

// File: rtl/team_turn_ctrl.sv
// Two-team turn scheduler for the snake game: alternates turns, accumulates
// saturating team totals and drives the status/score bus to the VGA path.
//
// state  | meaning
// IDLE   | waiting for start after reset
// PLAY   | a team is playing its turn
// COMMIT | one cycle: add the latched turn score to the team total
// HOLD   | turn-over screen, HOLD_CYCLES long
// DONE   | match over, winner shown, start begins a new match
module team_turn_ctrl
    import turn_pkg::*;
#(
    parameter int ROUNDS      = 3,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               snake_dead,
    input  logic [SCORE_W-1:0] score,
    output logic               round_reset,
    output logic [1:0]         game_status,
    output logic [1:0]         current_team,
    output logic [3:0]         round_idx,
    output logic [SCORE_W-1:0] team1_score,
    output logic [SCORE_W-1:0] team2_score,
    output logic               game_complete,
    output logic [1:0]         winner
);

    localparam int              HOLD_W     = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]      LAST_ROUND = 4'(ROUNDS - 1);

    fsm_state_t         state, state_next;
    logic [SCORE_W-1:0] latched_q, latched_next;
    logic [SCORE_W-1:0] team1_next, team2_next;
    logic [1:0]         team_next;
    logic [3:0]         round_next;
    logic               round_reset_next;
    logic [1:0]         winner_next;
    logic               timer_load;
    logic               timer_done;
    logic [HOLD_W-1:0]  hold_count_unused;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    hold_timer #(.W(HOLD_W)) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (HOLD_LOAD),
        .value      (hold_count_unused),
        .done       (timer_done)
    );

    always_comb begin
        state_next       = state;
        latched_next     = latched_q;
        team1_next       = team1_score;
        team2_next       = team2_score;
        team_next        = current_team;
        round_next       = round_idx;
        round_reset_next = 1'b0;
        timer_load       = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    team1_next       = '0;
                    team2_next       = '0;
                    round_next       = '0;
                    team_next        = TEAM1;
                    round_reset_next = 1'b1;
                    state_next       = S_PLAY;
                end
            end
            S_PLAY: begin
                if (snake_dead) begin
                    latched_next = score;
                    state_next   = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (current_team == TEAM1) begin
                    team1_next = sat_add(team1_score, latched_q);
                end else begin
                    team2_next = sat_add(team2_score, latched_q);
                end
                timer_load = 1'b1;
                state_next = S_HOLD;
            end
            S_HOLD: begin
                if (timer_done) begin
                    if (current_team == TEAM1) begin
                        team_next        = TEAM2;
                        round_reset_next = 1'b1;
                        state_next       = S_PLAY;
                    end else if (round_idx == LAST_ROUND) begin
                        state_next = S_DONE;
                    end else begin
                        team_next        = TEAM1;
                        round_next       = round_idx + 4'd1;
                        round_reset_next = 1'b1;
                        state_next       = S_PLAY;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Winner is registered alongside the DONE entry; totals are frozen there.
        winner_next = WIN_NONE;
        if (state_next == S_DONE) begin
            if (team1_next > team2_next)      winner_next = WIN_TEAM1;
            else if (team2_next > team1_next) winner_next = WIN_TEAM2;
            else                              winner_next = WIN_TIE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            latched_q     <= '0;
            team1_score   <= '0;
            team2_score   <= '0;
            current_team  <= TEAM_NONE;
            round_idx     <= '0;
            round_reset   <= 1'b0;
            game_status   <= ST_IDLE;
            game_complete <= 1'b0;
            winner        <= WIN_NONE;
        end else begin
            state         <= state_next;
            latched_q     <= latched_next;
            team1_score   <= team1_next;
            team2_score   <= team2_next;
            current_team  <= team_next;
            round_idx     <= round_next;
            round_reset   <= round_reset_next;
            game_status   <= status_of(state_next);
            game_complete <= (state_next == S_DONE);
            winner        <= winner_next;
        end
    end

endmodule

// File: doc/team_turn_ctrl.md
Name: team_turn_ctrl

Overview:
Two-team turn scheduler for the snake game. It sequences the shared snake playfield and VGA display between team 1 and team 2 and accumulates per-team totals. It drives game_status, current_team, team1_score, team2_score and game_complete into the VGA control path. It also issues a round_reset pulse that restarts the snake/apple/mine logic for each turn.

Parameters:
ROUNDS, 3, turns per team per match (1..15)
HOLD_CYCLES, 100_000_000, clk cycles the turn-over screen is held (1 s at 100 MHz); >=2
SCORE_W, 8, width of round and team scores

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse from the start button (debounced upstream)
snake_dead  input  1  single-cycle pulse: current turn has ended
score  input  SCORE_W  current turn score; valid on the snake_dead cycle
round_reset  output  1  single-cycle pulse: restart snake/apple/mines for a new turn
game_status  output  2  00 IDLE, 01 PLAY, 10 TURN_OVER, 11 END
current_team  output  2  00 none, 01 team1, 10 team2
round_idx  output  4  current round, 0-based
team1_score  output  SCORE_W  team 1 accumulated total
team2_score  output  SCORE_W  team 2 accumulated total
game_complete  output  1  high while in DONE
winner  output  2  01 team1, 10 team2, 11 tie; 00 unless in DONE

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; all outputs 0; current_team 00; hold counter 0.
- All outputs are registered.
- IDLE:
  - game_status 00.
  - On start: clear both totals, round_idx 0, current_team 01, go to PLAY.
  - round_reset pulses on the cycle PLAY is entered.
- PLAY:
  - game_status 01.
  - On snake_dead: latch score, go to COMMIT.
  - start is ignored.
- COMMIT (1 cycle):
  - game_status stays 01.
  - Add the latched score to the current team's total, saturating at 2^SCORE_W-1.
  - Load hold counter with HOLD_CYCLES-1; go to HOLD.
- HOLD:
  - game_status 10.
  - Counter decrements each cycle. At 0, evaluate the next turn:
    - current_team 01: set team 10, go to PLAY.
    - current_team 10 and round_idx == ROUNDS-1: go to DONE.
    - otherwise: team 01, round_idx+1, go to PLAY.
  - Every re-entry into PLAY pulses round_reset once.
- DONE:
  - game_status 11; game_complete 1.
  - winner compares the totals (equal gives 11).
  - Totals and current_team hold.
  - On start: behave as in IDLE (clear and restart at team 01, round 0).
- snake_dead outside PLAY is ignored. start outside IDLE/DONE is ignored.
- start and snake_dead in the same cycle: each is evaluated only in the state it applies to, so no conflict.
- Latency:
  - snake_dead to total updated: 2 cycles.
  - snake_dead to game_status 10: 2 cycles.
  - Turn-over screen lasts exactly HOLD_CYCLES cycles.
- Reset mid-operation: immediate return to the IDLE reset values; no round_reset pulse.

Decomposition:
- Package turn_pkg:
  - game_status codes (ST_IDLE/ST_PLAY/ST_TURN/ST_END)
  - team codes (TEAM_NONE/TEAM1/TEAM2)
  - winner codes
  - FSM state enum (IDLE, PLAY, COMMIT, HOLD, DONE)
- Sub-module hold_timer:
  - loadable down-counter with load, value and done outputs.
  - Width is $clog2(HOLD_CYCLES).
  - Reused later for the apple/mine respawn delays.

Test Plan:
- Setup: ROUNDS=2, HOLD_CYCLES=4. Reset asserted mid-HOLD -> all outputs 0 on the same edge; game_status 00.
- Basic turn: start -> round_reset pulses for 1 cycle, game_status 01, current_team 01. Then snake_dead with score=7 -> team1_score 7 two cycles later, game_status 10 for exactly 4 cycles. Then current_team 10 and another round_reset pulse.
- Full match: turn scores 5,9,3,1 (t1,t2,t1,t2) -> round_idx goes 0,0,1,1. Then DONE with team1_score 8, team2_score 10, winner 10, game_complete 1.
- Saturation: team1 turns of 200 and 100 -> team1_score 255.
- Tie: all four turn scores 4 -> winner 11. Then start in DONE -> totals 0, current_team 01, round_reset pulse.
- Ignored events: snake_dead in IDLE/HOLD/DONE and start in PLAY/HOLD -> no state or score change. start with snake_dead in IDLE -> PLAY entered with totals 0.
